// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - DIV/MTHI/MTLO sequencer driving the 32-iteration signed divider engine
// Owns HI/LO, stalls the pipeline during a divide, handles div-by-zero, cancel and engine-hang timeout.
module div_sequencer #(
  parameter int          TIMEOUT = 40,
  parameter logic [31:0] DIV0_LO = 32'hFFFFFFFF
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [1:0]  req_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        cancel,
  output logic        stall,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        div0_flag,
  output logic        err_timeout,
  output logic        eng_start,
  output logic        eng_reset,
  output logic [63:0] eng_operands,
  input  logic        eng_busy,
  input  logic [63:0] eng_result
);

  localparam int             CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [63:0]   ops_q, ops_d;
  logic          start_q, start_d, ereset_q, ereset_d;
  logic          div0_q, div0_d, err_q, err_d;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      ops_q    <= '0;
      start_q  <= 1'b0;
      ereset_q <= 1'b0;
      div0_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      ops_q    <= ops_d;
      start_q  <= start_d;
      ereset_q <= ereset_d;
      div0_q   <= div0_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    ops_d    = ops_q;
    start_d  = 1'b0;
    ereset_d = 1'b0;
    div0_d   = 1'b0;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && !cancel) begin
          case (req_op)
            2'b00: begin
              if (rt_data != 32'd0) begin
                ops_d   = {rs_data, rt_data};
                start_d = 1'b1;
                cnt_d   = '0;
                state_d = S_LAUNCH;
              end else begin
                hi_d    = rs_data;
                lo_d    = DIV0_LO;
                div0_d  = 1'b1;
                state_d = S_DONE;
              end
            end
            2'b01:   hi_d = rs_data;
            2'b10:   lo_d = rs_data;
            default: ;
          endcase
        end
      end
      // Priority in flight: cancel, then hang timeout, then engine progress.
      S_LAUNCH, S_WAIT: begin
        if (cancel) begin
          ereset_d = 1'b1;
          state_d  = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          err_d    = 1'b1;
          ereset_d = 1'b1;
          state_d  = S_DONE;
        end else if (state_q == S_LAUNCH) begin
          if (eng_busy) begin
            cnt_d   = '0;
            state_d = S_WAIT;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else if (!eng_busy) begin
          lo_d    = eng_result[63:32];
          hi_d    = eng_result[31:0];
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign stall = ((state_q == S_IDLE) && req_valid && (req_op == 2'b00)) ||
                 (state_q == S_LAUNCH) || (state_q == S_WAIT);

  assign hi_out       = hi_q;
  assign lo_out       = lo_q;
  assign div0_flag    = div0_q;
  assign err_timeout  = err_q;
  assign eng_start    = start_q;
  assign eng_reset    = ereset_q;
  assign eng_operands = ops_q;

endmodule

// File: tb/tb_div_sequencer.sv
// tb/tb_div_sequencer.sv - self-checking bench for div_sequencer with a behavioural engine stub
module tb_div_sequencer;

  localparam int          TIMEOUT = 40;
  localparam logic [31:0] DIV0_LO = 32'hFFFFFFFF;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [31:0] rs_data, rt_data;
  logic        cancel;
  logic        stall;
  logic [31:0] hi_out, lo_out;
  logic        div0_flag, err_timeout, eng_start, eng_reset;
  logic [63:0] eng_operands;
  logic        eng_busy;
  logic [63:0] eng_result;

  int compared   = 0;
  int mismatched = 0;
  logic [31:0] exp_hi = 0, exp_lo = 0;

  div_sequencer #(.TIMEOUT(TIMEOUT), .DIV0_LO(DIV0_LO)) dut (
    .clk_in(clk_in), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .rs_data(rs_data), .rt_data(rt_data), .cancel(cancel), .stall(stall),
    .hi_out(hi_out), .lo_out(lo_out), .div0_flag(div0_flag),
    .err_timeout(err_timeout), .eng_start(eng_start), .eng_reset(eng_reset),
    .eng_operands(eng_operands), .eng_busy(eng_busy), .eng_result(eng_result)
  );

  always #5 clk_in = ~clk_in;

  // Engine stub: busy for 32 cycles starting the cycle after eng_start; can be forced stuck busy.
  logic stuck = 1'b0;
  logic busy_q;
  int   left_q;
  logic signed [31:0] e_a, e_b;
  always @(posedge clk_in or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0; left_q <= 0; eng_result <= '0;
    end else if (eng_reset) begin
      busy_q <= 1'b0; left_q <= 0;
    end else if (eng_start) begin
      e_a = eng_operands[63:32];
      e_b = eng_operands[31:0];
      busy_q     <= 1'b1;
      left_q     <= 32;
      eng_result <= {e_a / e_b, e_a % e_b};
    end else if (busy_q) begin
      left_q <= left_q - 1;
      if (left_q == 1) busy_q <= 1'b0;
    end
  end
  assign eng_busy = stuck | busy_q;

  // Reference: truncating quotient, remainder from the division identity.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa - q * sb;
    return {q[31:0], r[31:0]};
  endfunction

  task automatic tick;
    @(negedge clk_in); #1;
  endtask

  task automatic idle_inputs;
    req_valid = 1'b0; req_op = 2'b11; rs_data = '0; rt_data = '0; cancel = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; idle_inputs();
    tick(); tick();
    compared++; if ({hi_out, lo_out} !== 64'd0) begin mismatched++; $display("FAIL reset_hilo got %h want 0", {hi_out, lo_out}); end
    compared++; if (eng_operands !== 64'd0) begin mismatched++; $display("FAIL reset_ops got %h want 0", eng_operands); end
    compared++; if ({stall, div0_flag, err_timeout, eng_start, eng_reset} !== 5'b0) begin
      mismatched++; $display("FAIL reset_flags got %b want 00000", {stall, div0_flag, err_timeout, eng_start, eng_reset}); end
    reset = 1'b0;
    exp_hi = 0; exp_lo = 0;
    tick();
  endtask

  task automatic run_div(input logic [31:0] a, input logic [31:0] b);
    int cyc, starts, start_at;
    logic ops_bad;
    logic [63:0] r;
    @(negedge clk_in);
    req_valid = 1'b1; req_op = 2'b00; rs_data = a; rt_data = b; #1;
    cyc = 0; starts = 0; start_at = -1; ops_bad = 1'b0;
    while (stall === 1'b1 && cyc < 100) begin
      if (eng_start === 1'b1) begin starts++; start_at = cyc; end
      if (cyc >= 1 && b != 0 && eng_operands !== {a, b}) ops_bad = 1'b1;
      tick(); cyc++;
    end
    req_valid = 1'b0;
    if (b == 0) begin
      exp_hi = a; exp_lo = DIV0_LO;
      compared++; if (cyc !== 1) begin mismatched++; $display("FAIL div0_stall got %0d want 1", cyc); end
      compared++; if (starts !== 0 || eng_start !== 1'b0) begin mismatched++; $display("FAIL div0_nostart got %0d want 0", starts); end
      compared++; if (div0_flag !== 1'b1) begin mismatched++; $display("FAIL div0_flag got %b want 1", div0_flag); end
    end else begin
      r = ref_div(a, b);
      exp_lo = r[63:32]; exp_hi = r[31:0];
      compared++; if (cyc !== 35) begin mismatched++; $display("FAIL div_stall_len got %0d want 35", cyc); end
      compared++; if (starts !== 1 || start_at !== 1) begin mismatched++; $display("FAIL div_start got %0d@%0d want 1@1", starts, start_at); end
      compared++; if (ops_bad !== 1'b0) begin mismatched++; $display("FAIL div_operands got unstable want %h", {a, b}); end
      compared++; if (div0_flag !== 1'b0) begin mismatched++; $display("FAIL div_noflag got %b want 0", div0_flag); end
    end
    compared++; if (hi_out !== exp_hi || lo_out !== exp_lo) begin
      mismatched++; $display("FAIL div_result %h/%h got hi=%h lo=%h want hi=%h lo=%h", a, b, hi_out, lo_out, exp_hi, exp_lo); end
  endtask

  task automatic run_mt(input logic [1:0] op, input logic [31:0] v);
    @(negedge clk_in);
    req_valid = 1'b1; req_op = op; rs_data = v; rt_data = $urandom; #1;
    compared++; if (stall !== 1'b0) begin mismatched++; $display("FAIL mt_nostall got %b want 0", stall); end
    tick();
    req_valid = 1'b0;
    if (op == 2'b01) exp_hi = v;
    if (op == 2'b10) exp_lo = v;
    compared++; if (hi_out !== exp_hi || lo_out !== exp_lo) begin
      mismatched++; $display("FAIL mt_op%0d got hi=%h lo=%h want hi=%h lo=%h", op, hi_out, lo_out, exp_hi, exp_lo); end
  endtask

  task automatic test_directed_div;
    run_div(32'd100, 32'd7);
    run_div(32'hFFFFFF9C, 32'd7);
    compared++; if ({hi_out, lo_out} !== {32'hFFFFFFFE, 32'hFFFFFFF2}) begin
      mismatched++; $display("FAIL neg_div got %h want fffffffefffffff2", {hi_out, lo_out}); end
    compared++; if (eng_operands !== 64'hFFFFFF9C_00000007) begin
      mismatched++; $display("FAIL neg_ops got %h want ffffff9c00000007", eng_operands); end
    run_div(32'h1234, 32'd0);
  endtask

  task automatic test_random;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0: begin
          a = $urandom;
          b = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom_range(1, 1000) * (($urandom_range(0, 1) == 1) ? -1 : 1);
          run_div(a, b);
        end
        1: run_mt(2'b01, $urandom);
        2: run_mt(2'b10, $urandom);
        default: run_mt(2'b11, $urandom);
      endcase
    end
  endtask

  task automatic test_cancel;
    int resets;
    run_mt(2'b01, 32'h1111_2222);
    run_mt(2'b10, 32'h3333_4444);
    @(negedge clk_in);
    req_valid = 1'b1; req_op = 2'b00; rs_data = 32'd100; rt_data = 32'd7; #1;
    for (int c = 0; c < 10; c++) tick();
    cancel = 1'b1; req_valid = 1'b0;
    tick();
    cancel = 1'b0;
    compared++; if (stall !== 1'b0) begin mismatched++; $display("FAIL cancel_stall got %b want 0", stall); end
    resets = 0;
    for (int c = 0; c < 40; c++) begin
      if (eng_reset === 1'b1) resets++;
      if (c < 39) tick();
    end
    compared++; if (resets !== 1) begin mismatched++; $display("FAIL cancel_reset_pulses got %0d want 1", resets); end
    compared++; if (hi_out !== exp_hi || lo_out !== exp_lo) begin
      mismatched++; $display("FAIL cancel_hilo got %h/%h want %h/%h", hi_out, lo_out, exp_hi, exp_lo); end
    // Cancel in IDLE blocks an MTHI.
    @(negedge clk_in);
    req_valid = 1'b1; req_op = 2'b01; rs_data = 32'hDEAD_BEEF; cancel = 1'b1;
    tick();
    idle_inputs();
    compared++; if (hi_out !== exp_hi) begin mismatched++; $display("FAIL idle_cancel_hi got %h want %h", hi_out, exp_hi); end
  endtask

  task automatic test_mthi_during_div;
    int cyc;
    @(negedge clk_in);
    req_valid = 1'b1; req_op = 2'b00; rs_data = 32'd9; rt_data = 32'd2; #1;
    tick();
    req_op = 2'b01; rs_data = 32'hAAAA5555; rt_data = 32'd0;
    cyc = 1;
    while (stall === 1'b1 && cyc < 100) begin tick(); cyc++; end
    compared++; if (cyc !== 35 || lo_out !== 32'd4 || hi_out !== 32'd1) begin
      mismatched++; $display("FAIL mthi_div_done got cyc=%0d hi=%h lo=%h want 35 1 4", cyc, hi_out, lo_out); end
    tick();
    tick();
    req_valid = 1'b0;
    exp_hi = 32'hAAAA5555; exp_lo = 32'd4;
    compared++; if (hi_out !== exp_hi || lo_out !== exp_lo) begin
      mismatched++; $display("FAIL mthi_after got hi=%h lo=%h want %h %h", hi_out, lo_out, exp_hi, exp_lo); end
  endtask

  task automatic test_timeout;
    int cyc;
    stuck = 1'b1;
    @(negedge clk_in);
    req_valid = 1'b1; req_op = 2'b00; rs_data = 32'd100; rt_data = 32'd7; #1;
    cyc = 0;
    while (stall === 1'b1 && cyc < 200) begin tick(); cyc++; end
    req_valid = 1'b0;
    compared++; if (cyc < TIMEOUT || cyc > TIMEOUT + 2) begin
      mismatched++; $display("FAIL timeout_len got %0d want %0d..%0d", cyc, TIMEOUT, TIMEOUT + 2); end
    compared++; if (err_timeout !== 1'b1 || eng_reset !== 1'b1) begin
      mismatched++; $display("FAIL timeout_flags got err=%b rst=%b want 1 1", err_timeout, eng_reset); end
    compared++; if (hi_out !== exp_hi || lo_out !== exp_lo) begin
      mismatched++; $display("FAIL timeout_hilo got %h/%h want %h/%h", hi_out, lo_out, exp_hi, exp_lo); end
    stuck = 1'b0;
    run_div(32'd50, 32'd5);
    compared++; if (err_timeout !== 1'b1) begin mismatched++; $display("FAIL timeout_sticky got %b want 1", err_timeout); end
  endtask

  task automatic test_reset_midop;
    @(negedge clk_in);
    req_valid = 1'b1; req_op = 2'b00; rs_data = 32'd77; rt_data = 32'd3; #1;
    for (int c = 0; c < 5; c++) tick();
    req_valid = 1'b0; reset = 1'b1; #1;
    compared++; if (stall !== 1'b0 || err_timeout !== 1'b0 || eng_operands !== 64'd0 || hi_out !== 32'd0) begin
      mismatched++; $display("FAIL async_reset got stall=%b err=%b ops=%h hi=%h want 0", stall, err_timeout, eng_operands, hi_out); end
    tick();
    reset = 1'b0;
    exp_hi = 0; exp_lo = 0;
    run_div(32'd100, 32'd7);
  endtask

  initial begin
    test_reset();
    test_directed_div();
    test_random();
    test_cancel();
    test_mthi_during_div();
    test_timeout();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
